// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS control unit: Moore FSM sequencing fetch/decode/execute/
// memory/write-back and driving datapath selects and write enables.
module mc_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       overflow,
  output logic       pc_wr,
  output logic [1:0] npc_sel,
  output logic       ir_wr,
  output logic       rf_wr,
  output logic       dm_wr,
  output logic [3:0] alu_ctrl,
  output logic       alu_src_b,
  output logic [1:0] ext_op,
  output logic       reg_dst,
  output logic       wb_sel,
  output logic [3:0] state,
  output logic       illegal
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_SUBU  = 6'b100011;
  localparam logic [5:0] FN_SLT   = 6'b101010;

  localparam logic [3:0] ALU_ADDU = 4'b0000;
  localparam logic [3:0] ALU_SUBU = 4'b0001;
  localparam logic [3:0] ALU_OR   = 4'b0010;
  localparam logic [3:0] ALU_PASB = 4'b0011;
  localparam logic [3:0] ALU_ADD  = 4'b0101;
  localparam logic [3:0] ALU_SLT  = 4'b0110;

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DCD    = 4'd1,
    EXE_R  = 4'd2,
    EXE_I  = 4'd3,
    MA     = 4'd4,
    MR     = 4'd5,
    MW     = 4'd6,
    WB_ALU = 4'd7,
    WB_MEM = 4'd8,
    BR     = 4'd9,
    JMP    = 4'd10
  } state_e;

  typedef struct packed {
    logic       pc_wr;
    logic [1:0] npc_sel;
    logic       ir_wr;
    logic       rf_wr;
    logic       dm_wr;
    logic [3:0] alu_ctrl;
    logic       alu_src_b;
    logic [1:0] ext_op;
    logic       reg_dst;
    logic       wb_sel;
  } ctrl_t;

  // Output bundle for the state about to be entered; registering this gives
  // glitch-free outputs that line up with state_q.
  function automatic ctrl_t ctrl_for(input state_e st, input logic [5:0] opc,
                                     input logic [5:0] fn);
    ctrl_t c;
    c = '0;
    case (st)
      FETCH: begin
        c.ir_wr = 1'b1;
        c.pc_wr = 1'b1;
      end
      EXE_R: begin
        case (fn)
          FN_SUBU: c.alu_ctrl = ALU_SUBU;
          FN_SLT:  c.alu_ctrl = ALU_SLT;
          default: c.alu_ctrl = ALU_ADDU;
        endcase
      end
      EXE_I: begin
        c.alu_src_b = 1'b1;
        case (opc)
          OP_ORI: begin
            c.alu_ctrl = ALU_OR;
            c.ext_op   = 2'b00;
          end
          OP_LUI: begin
            c.alu_ctrl = ALU_PASB;
            c.ext_op   = 2'b10;
          end
          default: begin
            c.alu_ctrl = ALU_ADD;
            c.ext_op   = 2'b01;
          end
        endcase
      end
      MA: begin
        c.alu_ctrl  = ALU_ADDU;
        c.alu_src_b = 1'b1;
        c.ext_op    = 2'b01;
      end
      MW: c.dm_wr = 1'b1;
      WB_ALU: begin
        c.rf_wr   = 1'b1;
        c.reg_dst = (opc == OP_RTYPE);
      end
      WB_MEM: begin
        c.rf_wr  = 1'b1;
        c.wb_sel = 1'b1;
      end
      BR: begin
        c.alu_ctrl = ALU_SUBU;
        c.npc_sel  = 2'b01;
      end
      JMP: begin
        c.pc_wr   = 1'b1;
        c.npc_sel = 2'b10;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  state_e state_q, state_d;
  ctrl_t  ctrl_q, ctrl_d;
  logic   ovf_q, ovf_d;

  always_comb begin
    state_d = FETCH;
    case (state_q)
      FETCH: state_d = DCD;
      DCD: begin
        case (op)
          OP_RTYPE: begin
            if (funct == FN_ADDU || funct == FN_SUBU || funct == FN_SLT)
              state_d = EXE_R;
            else
              state_d = FETCH;
          end
          OP_ORI, OP_LUI, OP_ADDI: state_d = EXE_I;
          OP_LW, OP_SW:            state_d = MA;
          OP_BEQ:                  state_d = BR;
          OP_J:                    state_d = JMP;
          default:                 state_d = FETCH;
        endcase
      end
      EXE_R, EXE_I: state_d = WB_ALU;
      MA:           state_d = (op == OP_LW) ? MR : MW;
      MR:           state_d = WB_MEM;
      default:      state_d = FETCH;
    endcase
  end

  always_comb begin
    ctrl_d = ctrl_for(state_d, op, funct);
    ovf_d  = (state_q == EXE_I) && (op == OP_ADDI) && overflow;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FETCH;
      ctrl_q  <= ctrl_for(FETCH, op, funct);
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_d;
      ovf_q   <= ovf_d;
    end
  end

  // Enables are gated by rst combinationally so nothing writes during reset;
  // the BR pc_wr term and illegal are the only input-dependent outputs.
  assign pc_wr     = ~rst & (ctrl_q.pc_wr | ((state_q == BR) & zero));
  assign ir_wr     = ~rst & ctrl_q.ir_wr;
  assign rf_wr     = ~rst & ctrl_q.rf_wr & ~ovf_q;
  assign dm_wr     = ~rst & ctrl_q.dm_wr;
  assign illegal   = ~rst & (state_q == DCD) & (state_d == FETCH);
  assign npc_sel   = ctrl_q.npc_sel;
  assign alu_ctrl  = ctrl_q.alu_ctrl;
  assign alu_src_b = ctrl_q.alu_src_b;
  assign ext_op    = ctrl_q.ext_op;
  assign reg_dst   = ctrl_q.reg_dst;
  assign wb_sel    = ctrl_q.wb_sel;
  assign state     = state_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed bench for mc_ctrl: walks each instruction class through its states
// and compares state and control outputs against hand-computed values.
module tb_mc_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       overflow;
  logic       pc_wr;
  logic [1:0] npc_sel;
  logic       ir_wr;
  logic       rf_wr;
  logic       dm_wr;
  logic [3:0] alu_ctrl;
  logic       alu_src_b;
  logic [1:0] ext_op;
  logic       reg_dst;
  logic       wb_sel;
  logic [3:0] state;
  logic       illegal;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mc_ctrl dut (
    .clk(clk), .rst(rst), .op(op), .funct(funct), .zero(zero),
    .overflow(overflow), .pc_wr(pc_wr), .npc_sel(npc_sel), .ir_wr(ir_wr),
    .rf_wr(rf_wr), .dm_wr(dm_wr), .alu_ctrl(alu_ctrl), .alu_src_b(alu_src_b),
    .ext_op(ext_op), .reg_dst(reg_dst), .wb_sel(wb_sel), .state(state),
    .illegal(illegal)
  );

  // Advance to the middle of the next cycle.
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; op = 6'b111111; funct = '0; zero = 1'b0; overflow = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      tests++; if ({pc_wr, ir_wr, rf_wr, dm_wr, illegal} !== 5'b0) begin fails++; $display("FAIL rst_enables cyc%0d got %b exp 00000", i, {pc_wr, ir_wr, rf_wr, dm_wr, illegal}); end
      tests++; if (state !== 4'd0) begin fails++; $display("FAIL rst_state got %0d exp 0", state); end
    end
    rst = 1'b0; #1;
    tests++; if (state !== 4'd0) begin fails++; $display("FAIL post_rst_state got %0d exp 0", state); end
    tests++; if ({pc_wr, ir_wr} !== 2'b11) begin fails++; $display("FAIL post_rst_fetch pc_wr/ir_wr got %b exp 11", {pc_wr, ir_wr}); end
  endtask

  task automatic test_rtype(input logic [5:0] fn, input logic [3:0] exp_alu);
    op = 6'b000000; funct = fn;
    tick();
    tests++; if (state !== 4'd1 || {pc_wr, ir_wr, rf_wr, dm_wr, illegal} !== 5'b0) begin fails++; $display("FAIL r_dcd fn=%b state %0d en %b exp 1/00000", fn, state, {pc_wr, ir_wr, rf_wr, dm_wr, illegal}); end
    tick();
    tests++; if (state !== 4'd2) begin fails++; $display("FAIL r_exe_state got %0d exp 2", state); end
    tests++; if (alu_ctrl !== exp_alu || alu_src_b !== 1'b0) begin fails++; $display("FAIL r_exe_alu fn=%b got %b/%b exp %b/0", fn, alu_ctrl, alu_src_b, exp_alu); end
    tick();
    tests++; if (state !== 4'd7 || rf_wr !== 1'b1 || reg_dst !== 1'b1 || wb_sel !== 1'b0) begin fails++; $display("FAIL r_wb state %0d rf_wr %b reg_dst %b wb_sel %b exp 7/1/1/0", state, rf_wr, reg_dst, wb_sel); end
    tick();
    tests++; if (state !== 4'd0 || ir_wr !== 1'b1 || rf_wr !== 1'b0) begin fails++; $display("FAIL r_next_fetch state %0d ir_wr %b rf_wr %b exp 0/1/0", state, ir_wr, rf_wr); end
  endtask

  task automatic test_lw_sw();
    op = 6'b100011; funct = 6'b000101;
    tick(); tick();
    tests++; if (state !== 4'd4 || alu_ctrl !== 4'b0000 || alu_src_b !== 1'b1 || ext_op !== 2'b01) begin fails++; $display("FAIL lw_ma state %0d alu %b srcb %b ext %b exp 4/0000/1/01", state, alu_ctrl, alu_src_b, ext_op); end
    tick();
    tests++; if (state !== 4'd5 || {rf_wr, dm_wr} !== 2'b00) begin fails++; $display("FAIL lw_mr state %0d rf/dm %b exp 5/00", state, {rf_wr, dm_wr}); end
    tick();
    tests++; if (state !== 4'd8 || rf_wr !== 1'b1 || wb_sel !== 1'b1 || reg_dst !== 1'b0) begin fails++; $display("FAIL lw_wb state %0d rf_wr %b wb_sel %b reg_dst %b exp 8/1/1/0", state, rf_wr, wb_sel, reg_dst); end
    tick();
    tests++; if (state !== 4'd0) begin fails++; $display("FAIL lw_next_fetch got %0d exp 0", state); end
    op = 6'b101011;
    tick(); tick();
    tests++; if (state !== 4'd4 || dm_wr !== 1'b0) begin fails++; $display("FAIL sw_ma state %0d dm_wr %b exp 4/0", state, dm_wr); end
    tick();
    tests++; if (state !== 4'd6 || dm_wr !== 1'b1 || rf_wr !== 1'b0) begin fails++; $display("FAIL sw_mw state %0d dm_wr %b rf_wr %b exp 6/1/0", state, dm_wr, rf_wr); end
    tick();
    tests++; if (state !== 4'd0 || dm_wr !== 1'b0) begin fails++; $display("FAIL sw_after state %0d dm_wr %b exp 0/0", state, dm_wr); end
  endtask

  task automatic test_beq(input logic z);
    op = 6'b000100; zero = 1'b0;
    tick(); tick();
    zero = z; #1;
    tests++; if (state !== 4'd9 || npc_sel !== 2'b01 || alu_ctrl !== 4'b0001 || alu_src_b !== 1'b0) begin fails++; $display("FAIL beq_br state %0d npc %b alu %b srcb %b exp 9/01/0001/0", state, npc_sel, alu_ctrl, alu_src_b); end
    tests++; if (pc_wr !== z) begin fails++; $display("FAIL beq_pc_wr zero=%b got %b exp %b", z, pc_wr, z); end
    tick(); zero = 1'b0;
    tests++; if (state !== 4'd0 || npc_sel !== 2'b00) begin fails++; $display("FAIL beq_next state %0d npc %b exp 0/00", state, npc_sel); end
  endtask

  task automatic test_jump();
    op = 6'b000010;
    tick(); tick();
    tests++; if (state !== 4'd10 || pc_wr !== 1'b1 || npc_sel !== 2'b10 || rf_wr !== 1'b0) begin fails++; $display("FAIL j_jmp state %0d pc_wr %b npc %b rf_wr %b exp 10/1/10/0", state, pc_wr, npc_sel, rf_wr); end
    tick();
    tests++; if (state !== 4'd0) begin fails++; $display("FAIL j_next got %0d exp 0", state); end
  endtask

  task automatic test_imm(input logic [5:0] opc, input logic [3:0] exp_alu,
                          input logic [1:0] exp_ext, input logic ovf,
                          input logic exp_rf);
    op = opc;
    tick(); tick();
    tests++; if (state !== 4'd3 || alu_ctrl !== exp_alu || ext_op !== exp_ext || alu_src_b !== 1'b1) begin fails++; $display("FAIL imm_exe op=%b state %0d alu %b ext %b srcb %b exp 3/%b/%b/1", opc, state, alu_ctrl, ext_op, alu_src_b, exp_alu, exp_ext); end
    overflow = ovf;
    tick(); overflow = 1'b0;
    tests++; if (state !== 4'd7 || rf_wr !== exp_rf || reg_dst !== 1'b0) begin fails++; $display("FAIL imm_wb op=%b ovf=%b state %0d rf_wr %b reg_dst %b exp 7/%b/0", opc, ovf, state, rf_wr, reg_dst, exp_rf); end
    tick();
    tests++; if (state !== 4'd0) begin fails++; $display("FAIL imm_next got %0d exp 0", state); end
  endtask

  task automatic test_illegal(input logic [5:0] opc, input logic [5:0] fn);
    op = opc; funct = fn;
    tests++; if (illegal !== 1'b0) begin fails++; $display("FAIL ill_fetch got %b exp 0", illegal); end
    tick();
    tests++; if (state !== 4'd1 || illegal !== 1'b1) begin fails++; $display("FAIL ill_dcd op=%b fn=%b state %0d illegal %b exp 1/1", opc, fn, state, illegal); end
    tick();
    tests++; if (state !== 4'd0 || illegal !== 1'b0 || ir_wr !== 1'b1) begin fails++; $display("FAIL ill_next state %0d illegal %b ir_wr %b exp 0/0/1", state, illegal, ir_wr); end
  endtask

  task automatic test_reset_mid();
    op = 6'b101011;
    tick(); tick(); tick();
    rst = 1'b1; #1;
    tests++; if (state !== 4'd6 || dm_wr !== 1'b0) begin fails++; $display("FAIL rstmid_mw state %0d dm_wr %b exp 6/0", state, dm_wr); end
    tick();
    tests++; if (state !== 4'd0 || {pc_wr, ir_wr, dm_wr} !== 3'b000) begin fails++; $display("FAIL rstmid_after state %0d en %b exp 0/000", state, {pc_wr, ir_wr, dm_wr}); end
    rst = 1'b0; #1;
    tests++; if ({pc_wr, ir_wr} !== 2'b11) begin fails++; $display("FAIL rstmid_release got %b exp 11", {pc_wr, ir_wr}); end
  endtask

  initial begin
    test_reset();
    test_rtype(6'b100001, 4'b0000);
    test_rtype(6'b100011, 4'b0001);
    test_rtype(6'b101010, 4'b0110);
    test_lw_sw();
    test_beq(1'b1);
    test_beq(1'b0);
    test_jump();
    test_imm(6'b001000, 4'b0101, 2'b01, 1'b1, 1'b0);
    test_imm(6'b001000, 4'b0101, 2'b01, 1'b0, 1'b1);
    test_imm(6'b001101, 4'b0010, 2'b00, 1'b0, 1'b1);
    test_imm(6'b001111, 4'b0011, 2'b10, 1'b0, 1'b1);
    test_illegal(6'b111111, 6'b000000);
    test_illegal(6'b000000, 6'b100000);
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
